// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling FSM and a small
// first-word-fall-through receive FIFO with sticky overrun/frame error flags.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_pop,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_full,
  output logic       busy,
  output logic       overrun_err,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_e;

  state_e             state_q, state_d;
  logic [1:0]         sync_q;
  logic               rx_s;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bitn_q, bitn_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               push;
  logic               ovr_set;
  logic               frm_set;
  logic               pop_fire;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               overrun_q, frame_q;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

  assign rx_valid = (count_q != '0);
  assign rx_full  = (count_q == CNT_FULL);
  assign pop_fire = rx_pop && rx_valid;
  assign rx_data  = mem_q[rd_ptr_q];

  // FSM state register and bit-timing datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state logic; a full FIFO still accepts when a pop frees a slot.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bitn_d  = bitn_q;
    shreg_d = shreg_q;
    push    = 1'b0;
    ovr_set = 1'b0;
    frm_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d  = '0;
          bitn_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          if (bitn_q == 3'd7) state_d = STOP;
          else                bitn_d  = bitn_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            if (!rx_full || pop_fire) push    = 1'b1;
            else                      ovr_set = 1'b1;
          end else begin
            state_d = BRK;
            frm_set = 1'b1;
          end
        end
      end
      BRK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy = (state_q != IDLE);
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop_fire)      count_d = count_q + CW'(1);
    else if (!push && pop_fire) count_d = count_q - CW'(1);
  end

  // Receive FIFO storage and pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= shreg_q;
        wr_ptr_q        <= wr_ptr_q + FIFO_AW'(1);
      end
      if (pop_fire) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      count_q <= count_d;
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      if (ovr_set)      overrun_q <= 1'b1;
      else if (clr_err) overrun_q <= 1'b0;
      if (frm_set)      frame_q   <= 1'b1;
      else if (clr_err) frame_q   <= 1'b0;
    end
  end

  assign overrun_err = overrun_q;
  assign frame_err   = frame_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serial frames in, FIFO bytes checked on pop.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       rx_pop;
  logic       clr_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_full;
  logic       busy;
  logic       overrun_err;
  logic       frame_err;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int rise_cyc  = -1;
  logic lat_arm   = 1'b0;
  logic valid_prev = 1'b0;
  logic [7:0] sb_q [$];

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_pop(rx_pop), .clr_err(clr_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full), .busy(busy),
    .overrun_err(overrun_err), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Records the first rx_valid rise while armed.
  always @(negedge clk) begin
    valid_prev <= rx_valid;
    if (!lat_arm) rise_cyc <= -1;
    else if (rx_valid && !valid_prev && rise_cyc < 0) rise_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pop_head(input string tag);
    logic [7:0] exp;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 8'h00;
    check({tag, "_valid"}, 32'(rx_valid), 32'd1);
    check({tag, "_data"}, 32'(rx_data), 32'(exp));
    rx_pop = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    @(negedge clk);
    pop_head(tag);
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; optionally pops at cycle pop_at or stops at abort_at.
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input int pop_at, input int abort_at);
    int b;
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      if (i == abort_at) return;
      if (i == 0) start_cyc = cyc;
      b = i / CPB;
      if (b == 0)      rx = 1'b0;
      else if (b == 9) rx = stop_b;
      else             rx = d[3'(b - 1)];
      if (i == pop_at) pop_head("pop_in_frame");
      else             rx_pop = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    reset = 1'b0; rx = 1'b1; rx_pop = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_full", 32'(rx_full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(rx_data), 32'h00);
    check("rst_errs", 32'({overrun_err, frame_err}), 32'd0);
    reset = 1'b1;
    idle(5);

    // 1: two frames, latency, FWFT order
    lat_arm = 1'b1;
    sb_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, -1, -1);
    idle(4);
    lat = rise_cyc - start_cyc;
    check("latency", 32'((lat >= 154 && lat <= 156) ? 155 : lat), 32'd155);
    lat_arm = 1'b0;
    sb_q.push_back(8'hA3);
    send_frame(8'hA3, 1'b1, -1, -1);
    idle(4);
    pop_check("t1_a");
    pop_check("t1_b");
    check("t1_empty", 32'(rx_valid), 32'd0);

    // 2: overrun with no pops
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) sb_q.push_back(8'(k));
      send_frame(8'(k), 1'b1, -1, -1);
      idle(4);
      if (k == 4) begin
        check("t2_full", 32'(rx_full), 32'd1);
        check("t2_no_ovr", 32'(overrun_err), 32'd0);
      end
    end
    check("t2_ovr", 32'(overrun_err), 32'd1);
    check("t2_full5", 32'(rx_full), 32'd1);
    for (int k = 0; k < 4; k++) pop_check("t2_pop");
    @(negedge clk);
    check("t2_empty", 32'(rx_valid), 32'd0);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    check("t2_clr", 32'(overrun_err), 32'd0);

    // 3: short glitch
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    check("t3_busy_start", 32'(busy), 32'd1);
    idle(30);
    check("t3_idle", 32'(busy), 32'd0);
    check("t3_valid", 32'(rx_valid), 32'd0);
    check("t3_errs", 32'({overrun_err, frame_err}), 32'd0);

    // 4: framing error then break held low
    send_frame(8'h81, 1'b0, -1, -1);
    check("t4_ferr", 32'(frame_err), 32'd1);
    check("t4_nopush", 32'(rx_valid), 32'd0);
    repeat (10) @(negedge clk);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    repeat (29) @(negedge clk);
    check("t4_break_busy", 32'(busy), 32'd1);
    idle(20);
    check("t4_once", 32'(frame_err), 32'd0);
    check("t4_idle", 32'(busy), 32'd0);
    sb_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, -1, -1);
    idle(4);
    pop_check("t4_3c");

    // 5: push and pop on the same cycle while full
    for (int k = 0; k < 4; k++) begin
      sb_q.push_back(8'h10 + 8'(k));
      send_frame(8'h10 + 8'(k), 1'b1, -1, -1);
      idle(4);
    end
    check("t5_full", 32'(rx_full), 32'd1);
    sb_q.push_back(8'h14);
    send_frame(8'h14, 1'b1, 154, -1);
    idle(4);
    check("t5_no_ovr", 32'(overrun_err), 32'd0);
    check("t5_still_full", 32'(rx_full), 32'd1);
    for (int k = 0; k < 4; k++) pop_check("t5_pop");
    @(negedge clk);
    check("t5_empty", 32'(rx_valid), 32'd0);

    // 6: reset mid-DATA with two bytes buffered
    for (int k = 0; k < 2; k++) begin
      sb_q.push_back(8'h21 + 8'(k));
      send_frame(8'h21 + 8'(k), 1'b1, -1, -1);
      idle(4);
    end
    check("t6_valid_pre", 32'(rx_valid), 32'd1);
    send_frame(8'h99, 1'b1, -1, 60);
    check("t6_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(rx_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_data", 32'(rx_data), 32'h00);
    sb_q.delete();
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle(5);
    sb_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, -1, -1);
    idle(4);
    pop_check("t6_7e");
    @(negedge clk);
    check("t6_empty", 32'(rx_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
